// File: rtl/key_conditioner_pkg.sv
// Shared constants, repeat-FSM state type and counter sizing helper for the key conditioner.
package key_conditioner_pkg;

  localparam int N_KEYS_DEF       = 3;
  localparam int DEBOUNCE_CYC_DEF = 20000;
  localparam int HOLD_CYC_DEF     = 500000;
  localparam int REPEAT_CYC_DEF   = 100000;

  localparam int KEY_4_IDX = 0;
  localparam int KEY_5_IDX = 1;
  localparam int KEY_6_IDX = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bus: raw key levels in, conditioned levels and single-cycle events out.
interface key_conditioner_if
  import key_conditioner_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEF
);

  logic [N_KEYS-1:0] i_key;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_repeat;
  logic              o_any_press;

  modport master (
    output i_key,
    input  o_level, o_press, o_release, o_repeat, o_any_press
  );

  modport slave (
    input  i_key,
    output o_level, o_press, o_release, o_repeat, o_any_press
  );

endinterface

// File: rtl/key_conditioner_key_channel.sv
// One key: 2-FF synchroniser, counter debounce, press/release pulses and auto-repeat FSM.
// state     | meaning
// ST_IDLE   | key released, no repeat timing
// ST_HOLD   | key held, counting towards the first repeat
// ST_REPEAT | key held past the first repeat, pulsing every REPEAT_CYC
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int REPEAT_CYC   = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam int HW = cnt_width((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  rep_state_e    state_q, state_d;

  always_comb begin
    level_d   = level_q;
    dcnt_d    = dcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == D_LAST) begin
      level_d   = sync2_q;
      dcnt_d    = '0;
      press_d   = sync2_q;
      release_d = ~sync2_q;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // A release always wins, so a repeat can never share a cycle with o_release.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    repeat_d = 1'b0;
    if (release_d) begin
      state_d = ST_IDLE;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_d) begin
            state_d = ST_HOLD;
            hcnt_d  = '0;
          end
        end
        ST_HOLD: begin
          if (hcnt_q == H_LAST) begin
            repeat_d = 1'b1;
            hcnt_d   = '0;
            state_d  = ST_REPEAT;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (hcnt_q == R_LAST) begin
            repeat_d = 1'b1;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      hcnt_q    <= '0;
      state_q   <= ST_IDLE;
    end else begin
      sync1_q   <= i_key;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button input stage: N_KEYS independent conditioned channels plus an any-press flag.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int N_KEYS       = N_KEYS_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int REPEAT_CYC   = REPEAT_CYC_DEF
) (
  input  logic          clk,
  input  logic          nrst,
  key_conditioner_if.slave key_bus
);

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [N_KEYS-1:0] rep;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_ch (
      .clk       (clk),
      .nrst      (nrst),
      .i_key     (key_bus.i_key[g]),
      .o_level   (level[g]),
      .o_press   (press[g]),
      .o_release (rel[g]),
      .o_repeat  (rep[g])
    );
  end

  assign key_bus.o_level     = level;
  assign key_bus.o_press     = press;
  assign key_bus.o_release   = rel;
  assign key_bus.o_repeat    = rep;
  assign key_bus.o_any_press = |press;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a window/elapsed-time reference model.
module tb_key_conditioner;
  import key_conditioner_pkg::*;

  localparam int NK = 3;
  localparam int D  = 16;
  localparam int H  = 64;
  localparam int R  = 16;

  logic clk  = 1'b0;
  logic nrst = 1'b1;

  key_conditioner_if #(.N_KEYS(NK)) bus ();

  key_conditioner #(
    .N_KEYS       (NK),
    .DEBOUNCE_CYC (D),
    .HOLD_CYC     (H),
    .REPEAT_CYC   (R)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .key_bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: a level flips once the last D synchronised samples all disagree with it;
  // repeats fall at press+H, press+H+R, ... while the level stays high.
  logic [D+1:0]    hist [NK];
  logic [NK-1:0]   m_lvl     = '0;
  logic [NK-1:0]   exp_press = '0;
  logic [NK-1:0]   exp_rel   = '0;
  logic [NK-1:0]   exp_rep   = '0;
  int              t_press [NK];
  int              m_cyc     = 0;

  initial begin
    logic [NK-1:0] np, nr, nq;
    for (int k = 0; k < NK; k++) begin
      hist[k]    = '0;
      t_press[k] = 0;
    end
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        for (int k = 0; k < NK; k++) hist[k] = '0;
        m_lvl     = '0;
        exp_press = '0;
        exp_rel   = '0;
        exp_rep   = '0;
      end else begin
        m_cyc++;
        np = '0;
        nr = '0;
        nq = '0;
        for (int k = 0; k < NK; k++) begin
          hist[k] = {hist[k][D:0], bus.i_key[k]};
          if (!m_lvl[k] && hist[k][D+1:2] == {D{1'b1}}) begin
            m_lvl[k]   = 1'b1;
            np[k]      = 1'b1;
            t_press[k] = m_cyc;
          end else if (m_lvl[k] && hist[k][D+1:2] == '0) begin
            m_lvl[k] = 1'b0;
            nr[k]    = 1'b1;
          end else if (m_lvl[k] && (m_cyc - t_press[k]) >= H &&
                       ((m_cyc - t_press[k] - H) % R) == 0) begin
            nq[k] = 1'b1;
          end
        end
        exp_press = np;
        exp_rel   = nr;
        exp_rep   = nq;
      end
    end
  end

  int press_cnt [NK];
  int rel_cnt   [NK];
  int rep_cnt   [NK];
  int p_t       [NK];
  int r_t       [NK];
  int any_cnt;
  int rep2_q [$];

  task automatic clear_mon();
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
      rep_cnt[k]   = 0;
      p_t[k]       = -1;
      r_t[k]       = -1;
    end
    any_cnt = 0;
    rep2_q.delete();
  endtask

  function automatic int rep_at(input int i);
    if (i < rep2_q.size()) return rep2_q[i];
    return -1;
  endfunction

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      chk("level",     int'(bus.o_level),     int'(m_lvl));
      chk("press",     int'(bus.o_press),     int'(exp_press));
      chk("release",   int'(bus.o_release),   int'(exp_rel));
      chk("repeat",    int'(bus.o_repeat),    int'(exp_rep));
      chk("any_press", int'(bus.o_any_press), int'(|exp_press));
      for (int k = 0; k < NK; k++) begin
        if (bus.o_press[k])   begin press_cnt[k]++; p_t[k] = cyc; end
        if (bus.o_release[k]) begin rel_cnt[k]++;   r_t[k] = cyc; end
        if (bus.o_repeat[k])  begin
          rep_cnt[k]++;
          if (k == KEY_6_IDX) rep2_q.push_back(cyc);
        end
      end
      if (bus.o_any_press) any_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t0;
    bus.i_key = '0;
    #1;
    nrst      = 1'b0;
    bus.i_key = 3'b111;
    tick(3);
    chk("rst_level",   int'(bus.o_level),     0);
    chk("rst_press",   int'(bus.o_press),     0);
    chk("rst_release", int'(bus.o_release),   0);
    chk("rst_repeat",  int'(bus.o_repeat),    0);
    chk("rst_any",     int'(bus.o_any_press), 0);

    // Keys held through reset
    clear_mon();
    nrst = 1'b1;
    e    = cyc + 1;
    tick(40);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("rst_hold_press_cnt%0d", k), press_cnt[k], 1);
      chk($sformatf("rst_hold_press_t%0d", k),   p_t[k],       e + 17);
    end
    chk("rst_hold_level", int'(bus.o_level), 7);
    chk("rst_hold_any",   any_cnt,           1);
    bus.i_key = '0;
    tick(40);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("rst_hold_rel_cnt%0d", k), rel_cnt[k], 1);
      chk($sformatf("rst_hold_rep_cnt%0d", k), rep_cnt[k], 0);
    end

    // Glitch one cycle short of the debounce window
    clear_mon();
    bus.i_key[KEY_4_IDX] = 1'b1;
    tick(15);
    bus.i_key[KEY_4_IDX] = 1'b0;
    tick(40);
    chk("glitch_press", press_cnt[0], 0);
    chk("glitch_rel",   rel_cnt[0],   0);
    chk("glitch_level", int'(bus.o_level), 0);

    // Exactly DEBOUNCE_CYC cycles is accepted
    clear_mon();
    bus.i_key[KEY_4_IDX] = 1'b1;
    e = cyc + 1;
    tick(16);
    bus.i_key[KEY_4_IDX] = 1'b0;
    tick(40);
    chk("edge16_press",   press_cnt[0],    1);
    chk("edge16_press_t", p_t[0],          e + 17);
    chk("edge16_width",   r_t[0] - p_t[0], 16);

    // Bounce on key_5
    clear_mon();
    for (int s = 0; s < 12; s++) begin
      bus.i_key[KEY_5_IDX] = (s % 2 == 0);
      tick(5);
    end
    bus.i_key[KEY_5_IDX] = 1'b1;
    e = cyc + 1;
    tick(30);
    chk("bounce_press_cnt", press_cnt[1],                1);
    chk("bounce_press_t",   p_t[1],                      e + 17);
    chk("bounce_others",    press_cnt[0] + press_cnt[2], 0);
    chk("bounce_no_rel",    rel_cnt[1],                  0);
    bus.i_key = '0;
    tick(40);
    chk("bounce_rel_cnt", rel_cnt[1], 1);

    // Hold/repeat on key_6
    clear_mon();
    bus.i_key[KEY_6_IDX] = 1'b1;
    e  = cyc + 1;
    t0 = e + 17;
    tick(200);
    bus.i_key[KEY_6_IDX] = 1'b0;
    tick(40);
    chk("hold_press_t", p_t[2],    t0);
    chk("hold_rep0",    rep_at(0), t0 + 64);
    chk("hold_rep1",    rep_at(1), t0 + 80);
    chk("hold_rep2",    rep_at(2), t0 + 96);
    chk("hold_rep_cnt", rep_cnt[2], 9);
    chk("hold_rel_t",   r_t[2],    e + 217);
    tick(40);
    chk("hold_rep_after_rel", rep_cnt[2], 9);

    // Staggered presses on key_4 and key_5
    clear_mon();
    bus.i_key[KEY_4_IDX] = 1'b1;
    e = cyc + 1;
    tick(3);
    bus.i_key[KEY_5_IDX] = 1'b1;
    tick(30);
    chk("stagger_t0",  p_t[0],          e + 17);
    chk("stagger_gap", p_t[1] - p_t[0], 3);
    chk("stagger_any", any_cnt,         2);
    bus.i_key = '0;
    tick(40);

    // Reset while key_6 is in auto-repeat
    clear_mon();
    bus.i_key[KEY_6_IDX] = 1'b1;
    tick(90);
    chk("mid_rep_before", rep_cnt[2], 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_level",  int'(bus.o_level),  0);
    chk("mid_rst_repeat", int'(bus.o_repeat), 0);
    chk("mid_rst_press",  int'(bus.o_press),  0);
    tick(3);
    clear_mon();
    nrst = 1'b1;
    e    = cyc + 1;
    tick(100);
    chk("mid_press_cnt", press_cnt[2], 1);
    chk("mid_press_t",   p_t[2],       e + 17);
    chk("mid_rep0",      rep_at(0),    e + 81);
    bus.i_key = '0;
    tick(40);
    chk("mid_rel_cnt", rel_cnt[2], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
